// File: rtl/rf_wb_pkg.sv
// Shared definitions for the register-file write-back arbiter.
//   - default widths and FIFO depth
//   - wb_src_e : write-back source encoding (ALU = 0, MEM = 1)
//   - wb_entry_t : one queued write (dest register + data) at default widths
//   - other_src() : the source that is not the given one (round-robin helper)
package rf_wb_pkg;

  localparam int DEF_FIFO_DEPTH = 2;
  localparam int DEF_ADDR_W     = 5;
  localparam int DEF_DATA_W     = 32;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] dest;
    logic [DEF_DATA_W-1:0] data;
  } wb_entry_t;

  function automatic wb_src_e other_src(input wb_src_e s);
    return (s == SRC_ALU) ? SRC_MEM : SRC_ALU;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO that holds pending register-file writes for one source.
// Ports:
//   clk, rst               clock (rising edge), asynchronous active-low reset
//   push, push_dest/data   enqueue request (ignored when full)
//   pop                    dequeue the head (ignored when empty)
//   head_dest/data         current head entry
//   full, empty, count     occupancy
//   ent_dest, ent_valid    every slot's dest and whether it holds a live
//                          entry, used by the hazard compare in the parent
module wb_fifo #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [ADDR_W-1:0]            push_dest,
  input  logic [DATA_W-1:0]            push_data,
  input  logic                         pop,
  output logic [ADDR_W-1:0]            head_dest,
  output logic [DATA_W-1:0]            head_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       count,
  output logic [DEPTH-1:0][ADDR_W-1:0] ent_dest,
  output logic [DEPTH-1:0]             ent_valid
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [PW-1:0]                rd_ptr;
  logic [PW-1:0]                wr_ptr;
  logic [PW:0]                  cnt;
  logic [DEPTH-1:0][ADDR_W-1:0] dest_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic                         do_push;
  logic                         do_pop;
  logic [PW-1:0]                offs;

  assign full      = (cnt == FULL_CNT);
  assign empty     = (cnt == '0);
  assign count     = cnt;
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_dest = dest_q[rd_ptr];
  assign head_data = data_q[rd_ptr];
  assign ent_dest  = dest_q;

  // Storage needs no reset: liveness comes from the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      dest_q[wr_ptr] <= push_dest;
      data_q[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // A slot is live when its distance past the read pointer is below count.
  always_comb begin
    ent_valid = '0;
    offs      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offs         = PW'(i) - rd_ptr;
      ent_valid[i] = ({1'b0, offs} < cnt);
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter between ALU results (src 0) and memory
// load returns (src 1).  Each source queues into its own wb_fifo; a
// round-robin arbiter drains one entry per cycle into a registered write
// stage that drives RegWrite / WriteRegister / WriteData.  Writes to r0 are
// drained silently.  Per-operand RAW hazard flags let decode stall while a
// source register has a write queued or in the write stage.
//
// Build option: define RF_WB_FWD_EN to forward the write-stage value to
// decode (fwdK_hit/fwdK_data) instead of flagging a hazard for it.  Without
// it the forwarding outputs are tied to zero.
//
// Ports:
//   clk, rst                          clock, async active-low reset
//   alu_valid/ready/dest/data         ALU write-back request channel
//   mem_valid/ready/dest/data         load write-back request channel
//   wr_en, wr_addr, wr_data           register-file write port
//   rs1_addr, rs2_addr                decode source registers
//   haz1, haz2                        source has a pending write
//   fwd1_hit/data, fwd2_hit/data      write-stage forwarding (option only)
//   busy                              anything queued or being written
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_dest,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_dest,
  input  logic [DATA_W-1:0] mem_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic              haz1,
  output logic              haz2,
  output logic              fwd1_hit,
  output logic              fwd2_hit,
  output logic [DATA_W-1:0] fwd1_data,
  output logic [DATA_W-1:0] fwd2_data,
  output logic              busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                              alu_full, mem_full;
  logic                              alu_empty, mem_empty;
  logic [CW-1:0]                     alu_cnt, mem_cnt;
  logic [ADDR_W-1:0]                 alu_hdest, mem_hdest;
  logic [DATA_W-1:0]                 alu_hdata, mem_hdata;
  logic [FIFO_DEPTH-1:0][ADDR_W-1:0] alu_edest, mem_edest;
  logic [FIFO_DEPTH-1:0]             alu_evalid, mem_evalid;
  logic                              alu_push, mem_push;
  logic                              alu_pop, mem_pop;

  wb_src_e           last_grant;
  logic              gnt;
  wb_src_e           gnt_src;
  logic [ADDR_W-1:0] gnt_dest;
  logic [DATA_W-1:0] gnt_data;

  logic fifo_hit1, fifo_hit2;
  logic wr_hit1, wr_hit2;
  logic nz1, nz2;

  // Ready depends on occupancy only, so a full FIFO refuses a push even in
  // a cycle where it is also being popped.
  assign alu_ready = !alu_full;
  assign mem_ready = !mem_full;
  assign alu_push  = alu_valid && alu_ready;
  assign mem_push  = mem_valid && mem_ready;

  wb_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_alu_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (alu_push),
    .push_dest (alu_dest),
    .push_data (alu_data),
    .pop       (alu_pop),
    .head_dest (alu_hdest),
    .head_data (alu_hdata),
    .full      (alu_full),
    .empty     (alu_empty),
    .count     (alu_cnt),
    .ent_dest  (alu_edest),
    .ent_valid (alu_evalid)
  );

  wb_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (mem_push),
    .push_dest (mem_dest),
    .push_data (mem_data),
    .pop       (mem_pop),
    .head_dest (mem_hdest),
    .head_data (mem_hdata),
    .full      (mem_full),
    .empty     (mem_empty),
    .count     (mem_cnt),
    .ent_dest  (mem_edest),
    .ent_valid (mem_evalid)
  );

  // Arbitration looks only at registered occupancy, so an entry pushed this
  // cycle cannot be granted until the next one.
  always_comb begin
    gnt     = !alu_empty || !mem_empty;
    gnt_src = SRC_ALU;
    if (!alu_empty && !mem_empty) begin
      gnt_src = other_src(last_grant);
    end else if (!mem_empty) begin
      gnt_src = SRC_MEM;
    end
    alu_pop  = gnt && (gnt_src == SRC_ALU);
    mem_pop  = gnt && (gnt_src == SRC_MEM);
    gnt_dest = (gnt_src == SRC_MEM) ? mem_hdest : alu_hdest;
    gnt_data = (gnt_src == SRC_MEM) ? mem_hdata : alu_hdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      last_grant <= SRC_MEM;
    end else if (gnt) begin
      wr_en      <= (gnt_dest != '0);
      wr_addr    <= gnt_dest;
      wr_data    <= gnt_data;
      last_grant <= gnt_src;
    end else begin
      wr_en      <= 1'b0;
    end
  end

  always_comb begin
    fifo_hit1 = 1'b0;
    fifo_hit2 = 1'b0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (alu_evalid[i] && (alu_edest[i] == rs1_addr)) fifo_hit1 = 1'b1;
      if (mem_evalid[i] && (mem_edest[i] == rs1_addr)) fifo_hit1 = 1'b1;
      if (alu_evalid[i] && (alu_edest[i] == rs2_addr)) fifo_hit2 = 1'b1;
      if (mem_evalid[i] && (mem_edest[i] == rs2_addr)) fifo_hit2 = 1'b1;
    end
  end

  assign nz1     = (rs1_addr != '0);
  assign nz2     = (rs2_addr != '0);
  assign wr_hit1 = wr_en && (wr_addr == rs1_addr);
  assign wr_hit2 = wr_en && (wr_addr == rs2_addr);

`ifdef RF_WB_FWD_EN
  // A queued write is younger than the write stage, so it must stall decode
  // even when the write stage could forward an older value.
  always_comb begin
    haz1      = nz1 && fifo_hit1;
    haz2      = nz2 && fifo_hit2;
    fwd1_hit  = nz1 && wr_hit1 && !fifo_hit1;
    fwd2_hit  = nz2 && wr_hit2 && !fifo_hit2;
    fwd1_data = fwd1_hit ? wr_data : '0;
    fwd2_data = fwd2_hit ? wr_data : '0;
  end
`else
  always_comb begin
    haz1      = nz1 && (fifo_hit1 || wr_hit1);
    haz2      = nz2 && (fifo_hit2 || wr_hit2);
    fwd1_hit  = 1'b0;
    fwd2_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_data = '0;
  end
`endif

  assign busy = (alu_cnt != '0) || (mem_cnt != '0) || wr_en;

endmodule
